branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Consumes the br_eq / br_lt / br_ltu flags produced in EX and decides each conditional branch's outcome.
- Predicts direction in ID from a 2-bit saturating branch history table (BHT), then checks that prediction in EX.
- On a mispredict, issues a registered redirect/flush to the pipelined Otter fetch stage.
- Keeps wrap-around branch and mispredict counters for performance debug.

Parameters:
- BHT_IDX_W, 4, log2 of BHT entry count (16 entries); index = pc[BHT_IDX_W+1:2]
- CNT_W, 32, width of the performance counters

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- id_pc  in  32  PC of the instruction in ID
- id_is_branch  in  1  ID instruction is a conditional branch (opcode 1100011)
- id_pred_taken  out  1  combinational prediction for the ID instruction
- ex_valid  in  1  EX holds a live instruction
- ex_stall  in  1  EX is held this cycle; no resolve
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_funct3  in  3  branch funct3 of the EX instruction
- ex_pc  in  32  PC of the EX instruction
- ex_target  in  32  computed branch target (pc + B-imm)
- ex_pred_taken  in  1  prediction made in ID, piped to EX
- br_eq  in  1  a == b
- br_lt  in  1  signed a < b
- br_ltu  in  1  unsigned a < b
- redirect_valid  out  1  registered; fetch must load redirect_pc, IF/ID/EX must flush
- redirect_pc  out  32  registered corrected PC
- ex_illegal_br  out  1  registered; funct3 010/011 resolved this cycle
- branch_count  out  CNT_W  branches resolved
- mispredict_count  out  CNT_W  mispredicts detected

Behaviour:
- Reset (async, RST_N low):
  - redirect_valid=0, redirect_pc=0, ex_illegal_br=0, both counters=0.
  - Every BHT entry = 2'b01 (weakly not-taken).
  - Reset mid-resolve discards the pending redirect.
- Prediction: id_pred_taken = id_is_branch & bht[id_pc idx][1]. Purely combinational, zero latency.
- Resolve condition: resolve = ex_valid & ex_is_branch & ~ex_stall & ~redirect_valid. While redirect_valid=1, the EX instruction is wrong-path and is ignored.
- Taken decode by funct3:
  - 000 eq; 001 ~eq
  - 100 lt; 101 ~lt
  - 110 ltu; 111 ~ltu
  - 010/011: not taken, counted as a branch, no BHT update, ex_illegal_br=1 next cycle.
- Mispredict = resolve & legal & (taken != ex_pred_taken).
- Next cycle after a mispredict:
  - redirect_valid=1.
  - redirect_pc = taken ? ex_target : ex_pc + 32'd4 (mod 2^32; wraps at 0xFFFFFFFC).
- redirect_valid is a single-cycle pulse. redirect_pc holds its value until the next redirect.
- BHT update on resolve & legal. Per-entry state machine SNT(00) <-> WNT(01) <-> WT(10) <-> ST(11):
  - taken increments, saturating at 11.
  - not-taken decrements, saturating at 00.
  - Update is written at the clock edge ending the resolve cycle.
- Same-cycle read/write to the same index: ID reads the old value (no bypass).
- Counters:
  - branch_count += 1 on every resolve.
  - mispredict_count += 1 on every mispredict.
  - Both wrap from all-ones to 0.
- ex_stall=1 with a valid branch: no update, no count, no redirect. Resolution happens in the first unstalled cycle.

Decomposition:
- Shared package otter_br_pkg holds:
  - funct3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - 2-bit counter state enum SNT/WNT/WT/ST.
  - Reset value WNT.
- One sub-module, bht_sat_table: register array with the combinational read port and the saturating write port.

Test Plan:
1. Reset, then id_pc=0x100, id_is_branch=1 -> id_pred_taken=0; all outputs 0.
2. BEQ at ex_pc=0x100, br_eq=1, ex_pred_taken=0, ex_target=0x140 -> next cycle redirect_valid=1 for exactly one cycle, redirect_pc=0x140, mispredict_count=1, branch_count=1; afterwards id_pc=0x100 predicts 1 (WT).
3. BLTU with br_ltu=0, ex_pred_taken=1, ex_pc=0x200 -> redirect_pc=0x204; entry trained from 11 down to 10.
4. Four consecutive taken resolves at one index -> entry saturates at 11; a fifth taken with pred=1 -> no redirect, branch_count increments only.
5. Mispredict followed by a valid branch in EX on the next cycle -> that branch is ignored (no count, no update). Same-index ID read during an EX write returns the old prediction.
6. funct3=010 -> ex_illegal_br=1, no BHT change, branch_count+1. Also, RST_N pulsed low mid-cycle during a mispredict -> redirect_valid=0 immediately, counters=0.

Source files
------------

// File: rtl/otter_br_pkg.sv
// Shared branch-resolve definitions: funct3 encodings, 2-bit BHT counter states
// and the saturating counter step.
package otter_br_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    localparam bht_state_e BHT_RESET = WNT;

    function automatic bht_state_e bht_next(input bht_state_e cur, input logic taken);
        bht_state_e nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = bht_state_e'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = bht_state_e'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_sat_table.sv
// Branch history table: 2-bit saturating counters with one combinational read
// port and one write port that applies the saturating step at the clock edge.
module bht_sat_table
    import otter_br_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_state_e       rd_state,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    bht_state_e bht_q [ENTRIES];
    bht_state_e bht_d [ENTRIES];

    // Read returns the pre-edge value even when the same entry is being written.
    assign rd_state = bht_q[rd_idx];

    always_comb begin
        bht_d = bht_q;
        if (wr_en) bht_d[wr_idx] = bht_next(bht_q[wr_idx], wr_taken);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < ENTRIES; i++) bht_q[i] <= BHT_RESET;
        end else begin
            bht_q <= bht_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Conditional-branch resolve: BHT prediction in ID, outcome check in EX,
// registered redirect on mispredict, and wrap-around performance counters.
module branch_resolve_unit
    import otter_br_pkg::*;
#(
    parameter int BHT_IDX_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      id_pc,
    input  logic             id_is_branch,
    output logic             id_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_is_branch,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic             br_eq,
    input  logic             br_lt,
    input  logic             br_ltu,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             ex_illegal_br,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    logic [BHT_IDX_W-1:0] id_idx;
    logic [BHT_IDX_W-1:0] ex_idx;
    bht_state_e           id_state;
    logic                 resolve;
    logic                 legal;
    logic                 taken;
    logic                 mispredict;

    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic id_pc_unused;
    assign id_pc_unused = ^{id_pc[31:BHT_IDX_W+2], id_pc[1:0]};

    assign id_idx        = id_pc[BHT_IDX_W+1:2];
    assign ex_idx        = ex_pc[BHT_IDX_W+1:2];
    assign id_pred_taken = id_is_branch & id_state[1];

    always_comb begin
        legal = 1'b1;
        taken = 1'b0;
        case (ex_funct3)
            BEQ:     taken = br_eq;
            BNE:     taken = ~br_eq;
            BLT:     taken = br_lt;
            BGE:     taken = ~br_lt;
            BLTU:    taken = br_ltu;
            BGEU:    taken = ~br_ltu;
            default: legal = 1'b0;
        endcase
    end

    // The cycle right after a redirect carries a wrong-path instruction in EX.
    assign resolve    = ex_valid & ex_is_branch & ~ex_stall & ~redirect_valid_q;
    assign mispredict = resolve & legal & (taken != ex_pred_taken);

    bht_sat_table #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .rd_idx   (id_idx),
        .rd_state (id_state),
        .wr_en    (resolve & legal),
        .wr_idx   (ex_idx),
        .wr_taken (taken)
    );

    always_comb begin
        redirect_valid_d   = mispredict;
        redirect_pc_d      = redirect_pc_q;
        illegal_d          = resolve & ~legal;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (mispredict) redirect_pc_d = taken ? ex_target : ex_pc + 32'd4;
        if (resolve) branch_count_d = branch_count_q + CNT_W'(1);
        if (mispredict) mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= 32'd0;
            illegal_q          <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            illegal_q          <= illegal_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign ex_illegal_br    = illegal_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized scoreboard bench for branch_resolve_unit against a behavioural model.
module tb_branch_resolve_unit;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] id_pc = '0;
    logic        id_is_branch = 1'b0;
    logic        id_pred_taken;
    logic        ex_valid = 1'b0;
    logic        ex_stall = 1'b0;
    logic        ex_is_branch = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        br_eq, br_lt, br_ltu;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ex_illegal_br;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    assign br_eq  = (op_a == op_b);
    assign br_lt  = ($signed(op_a) < $signed(op_b));
    assign br_ltu = (op_a < op_b);

    always #5 CLK = ~CLK;

    branch_resolve_unit dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .id_pc            (id_pc),
        .id_is_branch     (id_is_branch),
        .id_pred_taken    (id_pred_taken),
        .ex_valid         (ex_valid),
        .ex_stall         (ex_stall),
        .ex_is_branch     (ex_is_branch),
        .ex_funct3        (ex_funct3),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .br_eq            (br_eq),
        .br_lt            (br_lt),
        .br_ltu           (br_ltu),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .ex_illegal_br    (ex_illegal_br),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    typedef struct {
        bit          rv;
        logic [31:0] rpc;
        bit          ill;
        logic [31:0] bc;
        logic [31:0] mc;
        bit          pred;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Reference state: counter value 0..3 per entry plus the architectural outputs.
    int          m_bht[16];
    bit          m_rv;
    logic [31:0] m_rpc;
    bit          m_ill;
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic bit model_pred(input logic [31:0] pc);
        return m_bht[pc[5:2]] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_rv = 0; m_rpc = 0; m_ill = 0; m_bc = 0; m_mc = 0;
    endtask

    task automatic model_edge();
        bit res, legal, tk, mis;
        res   = ex_valid && ex_is_branch && !ex_stall && !m_rv;
        legal = !(ex_funct3 == 3'd2 || ex_funct3 == 3'd3);
        case (ex_funct3)
            3'd0:    tk = (op_a == op_b);
            3'd1:    tk = (op_a != op_b);
            3'd4:    tk = ($signed(op_a) <  $signed(op_b));
            3'd5:    tk = ($signed(op_a) >= $signed(op_b));
            3'd6:    tk = (op_a <  op_b);
            3'd7:    tk = (op_a >= op_b);
            default: tk = 0;
        endcase
        mis = res && legal && (tk != ex_pred_taken);
        if (mis) m_rpc = tk ? ex_target : ex_pc + 32'd4;
        m_ill = res && !legal;
        if (res) m_bc = m_bc + 1;
        if (mis) m_mc = m_mc + 1;
        if (res && legal) begin
            if (tk) m_bht[ex_pc[5:2]] = (m_bht[ex_pc[5:2]] == 3) ? 3 : m_bht[ex_pc[5:2]] + 1;
            else    m_bht[ex_pc[5:2]] = (m_bht[ex_pc[5:2]] == 0) ? 0 : m_bht[ex_pc[5:2]] - 1;
        end
        m_rv = mis;
    endtask

    // Called just after a rising edge once the inputs for this cycle are set.
    task automatic issue();
        exp_t e;
        e.rv   = m_rv;
        e.rpc  = m_rpc;
        e.ill  = m_ill;
        e.bc   = m_bc;
        e.mc   = m_mc;
        e.pred = id_is_branch && model_pred(id_pc);
        sb_q.push_back(e);
        model_edge();
    endtask

    task automatic set_idle(input logic [31:0] ipc, input bit ibr);
        @(posedge CLK); #1;
        id_pc = ipc; id_is_branch = ibr;
        ex_valid = 0; ex_stall = 0; ex_is_branch = 0;
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                          input bit pred, input logic [31:0] a, input logic [31:0] b);
        @(posedge CLK); #1;
        id_pc = pc; id_is_branch = 1;
        ex_valid = 1; ex_stall = 0; ex_is_branch = 1;
        ex_funct3 = f3; ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
        op_a = a; op_b = b;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("id_pred_taken",    {31'd0, id_pred_taken},  {31'd0, e.pred});
                chk("redirect_valid",   {31'd0, redirect_valid}, {31'd0, e.rv});
                chk("redirect_pc",      redirect_pc,             e.rpc);
                chk("ex_illegal_br",    {31'd0, ex_illegal_br},  {31'd0, e.ill});
                chk("branch_count",     branch_count,            e.bc);
                chk("mispredict_count", mispredict_count,        e.mc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        model_reset();
        #23 RST_N = 1;

        set_idle(32'h100, 1); issue();
        // BEQ taken, predicted not-taken; ID reads the same entry during the write
        set_br(3'd0, 32'h100, 32'h140, 0, 32'd5, 32'd5); issue();
        set_idle(32'h100, 1); issue();
        set_idle(32'h100, 1); issue();
        set_br(3'd0, 32'h100, 32'h140, 1, 32'd7, 32'd7); issue();
        set_br(3'd6, 32'h200, 32'h280, 1, 32'd9, 32'd3); issue();
        set_idle(32'h200, 1); issue();
        set_idle(32'h200, 1); issue();

        for (int k = 0; k < 5; k++) begin
            set_br(3'd5, 32'h1C4, 32'h400, model_pred(32'h1C4), 32'd4, 32'd4); issue();
            set_idle(32'h1C4, 1); issue();
        end

        // Mispredict, then a live branch immediately behind it must be ignored.
        set_br(3'd1, 32'h048, 32'h010, 1, 32'd3, 32'd3); issue();
        set_br(3'd4, 32'h048, 32'h020, 0, 32'hFFFF_FFFF, 32'd1); issue();
        set_idle(32'h048, 1); issue();

        // Stalled branch does nothing until the stall drops.
        set_br(3'd4, 32'h04C, 32'h090, 0, 32'hFFFF_FFFF, 32'd1); ex_stall = 1; issue();
        set_br(3'd4, 32'h04C, 32'h090, 0, 32'hFFFF_FFFF, 32'd1); issue();
        set_idle(32'h04C, 1); issue();

        set_br(3'd2, 32'h060, 32'h070, 0, 32'd1, 32'd2); issue();
        set_br(3'd3, 32'h060, 32'h070, 1, 32'd1, 32'd2); issue();
        set_idle(32'h060, 1); issue();

        // Fall-through address wraps past the top of memory.
        set_br(3'd1, 32'hFFFF_FFFC, 32'h100, 1, 32'd8, 32'd8); issue();
        set_idle(32'h0, 0); issue();
        set_idle(32'h0, 0); issue();

        // Async reset while a redirect is being presented.
        set_br(3'd0, 32'h0A0, 32'h0C0, 0, 32'd1, 32'd1); issue();
        @(posedge CLK); #2;
        ex_valid = 0; id_pc = 32'h100; id_is_branch = 1;
        RST_N = 0; #1;
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc",    redirect_pc,             32'd0);
        chk("rst_branch_count",   branch_count,            32'd0);
        chk("rst_mispred_count",  mispredict_count,        32'd0);
        chk("rst_pred",           {31'd0, id_pred_taken},  32'd0);
        model_reset();
        #2 RST_N = 1;

        for (int n = 0; n < 800; n++) begin
            @(posedge CLK); #1;
            id_pc         = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            id_is_branch  = ($urandom_range(0, 3) != 0);
            ex_valid      = ($urandom_range(0, 9) < 8);
            ex_is_branch  = ($urandom_range(0, 9) < 8);
            ex_stall      = ($urandom_range(0, 9) < 2);
            ex_funct3     = 3'($urandom_range(0, 7));
            ex_pc         = (n % 50 == 7) ? 32'hFFFF_FFFC : {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            ex_target     = $urandom & 32'hFFFF_FFFC;
            ex_pred_taken = ($urandom_range(0, 3) != 0) ? model_pred(ex_pc) : 1'($urandom_range(0, 1));
            op_a          = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 4));
            op_b          = ($urandom_range(0, 2) == 0) ? op_a
                          : (($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 4)));
            issue();
        end

        set_idle(32'h0, 0); issue();
        @(negedge CLK); #1;
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
